// File: rtl/aging_table_responder.sv
// Connection aging table: one {tag, timestamp} entry per connection.
// Arbitrates table writes between delete, refresh and inspector writes
// (one commit per cycle) and answers inspector reads with 2-cycle latency.
module aging_table_responder #(
   parameter int w_agingTb          = 9,
   parameter int d_agingTb          = 9,
   parameter int w_timestamp        = 8,
   parameter int b_agingTag_agingTb = 9
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [d_agingTb-1:0]   idx_agingTb,
   input  logic [w_agingTb-1:0]   data_agingTb,
   input  logic                   rdValid_agingTb,
   input  logic                   wrValid_agingTb,
   output logic [w_agingTb-1:0]   ctx_agingTb,
   input  logic                   upd_valid,
   input  logic [d_agingTb-1:0]   upd_idx,
   input  logic                   del_valid,
   input  logic [d_agingTb-1:0]   del_idx,
   input  logic [w_timestamp-1:0] cur_timestamp,
   output logic                   tb_ready,
   output logic [15:0]            drop_cnt
);

   localparam int N_ENT = 1 << d_agingTb;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   // Builds a table entry from tag and timestamp; unused bits stay zero.
   function automatic logic [w_agingTb-1:0] mk_entry(input logic tag,
                                                    input logic [w_timestamp-1:0] ts);
      logic [w_agingTb-1:0] e;
      e = '0;
      e[w_timestamp-1:0] = ts;
      e[b_agingTag_agingTb-1] = tag;
      return e;
   endfunction

   // Saturating increment for the drop counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   localparam logic [w_agingTb-1:0] AGED_ENTRY = mk_entry(1'b1, '0);

   logic [w_agingTb-1:0] r_mem [N_ENT];

   state_t               r_state, w_state_nxt;
   logic [d_agingTb-1:0] r_init_cnt;
   logic                 r_tb_ready;
   logic [15:0]          r_drop_cnt;
   logic [w_agingTb-1:0] r_ctx;

   // Refresh hold (refresh that lost to a delete) and inspector write hold.
   logic                 r_uh_vld;
   logic [d_agingTb-1:0] r_uh_idx;
   logic [w_agingTb-1:0] r_uh_data;
   logic                 r_ih_vld;
   logic [d_agingTb-1:0] r_ih_idx;
   logic [w_agingTb-1:0] r_ih_data;

   logic                 r_rd_vld_p1, r_rd_excl_p1, r_rd_vld_p2;
   logic [d_agingTb-1:0] r_rd_idx_p1;
   logic [w_agingTb-1:0] r_rd_data_p1, r_rd_data_p2;

   logic                 w_run, w_del, w_updf, w_insf, w_rd, w_excl;
   logic                 w_upd_go, w_slot, w_hold_live, w_fresh_live;
   logic                 w_hold_hit, w_fresh_hit;
   logic [d_agingTb-1:0] w_upd_idx;
   logic [w_agingTb-1:0] w_upd_data;
   logic                 w_we, w_wsrc_ins, w_wsrc_fresh;
   logic [d_agingTb-1:0] w_widx;
   logic [w_agingTb-1:0] w_wdata;
   logic                 w_uh_vld_nxt, w_uh_load;
   logic                 w_ih_vld_nxt, w_ih_load, w_drop;
   logic [d_agingTb-1:0] w_ih_idx_nxt;
   logic [w_agingTb-1:0] w_ih_data_nxt;
   logic [w_agingTb-1:0] w_rd_fwd_p0, w_rd_fwd_p1;

   assign w_run  = (r_state == ST_RUN);
   assign w_del  = w_run && del_valid;
   assign w_updf = w_run && upd_valid;
   assign w_insf = w_run && wrValid_agingTb;
   assign w_rd   = w_run && rdValid_agingTb;
   // Read and write share the index, so both valid means same-entry access.
   assign w_excl = w_rd && w_insf;

   // Sweep state: leave INIT after the last entry has been written.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_INIT && r_init_cnt == '1) w_state_nxt = ST_RUN;
   end

   // State, sweep counter and readiness flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         r_tb_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
         r_tb_ready <= (w_state_nxt == ST_RUN);
      end
   end

   // A held refresh goes ahead of a fresh one; deletes pre-empt both.
   assign w_upd_go   = !w_del && (r_uh_vld || w_updf);
   assign w_upd_idx  = r_uh_vld ? r_uh_idx : upd_idx;
   assign w_upd_data = r_uh_vld ? r_uh_data : mk_entry(1'b0, cur_timestamp);
   assign w_slot     = !w_del && !w_upd_go;

   // Inspector writes colliding with any delete/refresh activity on the same
   // entry are dropped silently, so a refresh is never overwritten as aged.
   assign w_hold_hit  = (w_del && r_ih_idx == del_idx) ||
                        (w_updf && r_ih_idx == upd_idx) ||
                        (r_uh_vld && r_ih_idx == r_uh_idx);
   assign w_fresh_hit = (w_del && idx_agingTb == del_idx) ||
                        (w_updf && idx_agingTb == upd_idx) ||
                        (r_uh_vld && idx_agingTb == r_uh_idx);
   assign w_hold_live  = r_ih_vld && !w_hold_hit;
   assign w_fresh_live = w_insf && !w_fresh_hit;

   // Write-port mux: sweep, then delete > refresh > held > fresh inspector.
   always_comb begin
      w_we         = 1'b0;
      w_widx       = '0;
      w_wdata      = '0;
      w_wsrc_ins   = 1'b0;
      w_wsrc_fresh = 1'b0;
      if (!w_run) begin
         w_we    = 1'b1;
         w_widx  = r_init_cnt;
         w_wdata = AGED_ENTRY;
      end else if (w_del) begin
         w_we    = 1'b1;
         w_widx  = del_idx;
         w_wdata = AGED_ENTRY;
      end else if (w_upd_go) begin
         w_we    = 1'b1;
         w_widx  = w_upd_idx;
         w_wdata = w_upd_data;
      end else if (w_hold_live) begin
         w_we       = 1'b1;
         w_widx     = r_ih_idx;
         w_wdata    = r_ih_data;
         w_wsrc_ins = 1'b1;
      end else if (w_fresh_live) begin
         w_we         = 1'b1;
         w_widx       = idx_agingTb;
         w_wdata      = data_agingTb;
         w_wsrc_ins   = 1'b1;
         w_wsrc_fresh = 1'b1;
      end
   end

   // Next contents of both hold registers and the drop event.
   always_comb begin
      w_uh_vld_nxt  = 1'b0;
      w_uh_load     = 1'b0;
      if (w_del) begin
         if (w_updf && upd_idx != del_idx) begin
            w_uh_vld_nxt = 1'b1;
            w_uh_load    = 1'b1;
         end else begin
            w_uh_vld_nxt = r_uh_vld && (r_uh_idx != del_idx);
         end
      end else if (r_uh_vld && w_updf) begin
         w_uh_vld_nxt = 1'b1;
         w_uh_load    = 1'b1;
      end

      w_ih_vld_nxt  = w_hold_live;
      w_ih_load     = 1'b0;
      w_drop        = 1'b0;
      if (w_slot) begin
         w_ih_vld_nxt = w_hold_live && w_fresh_live;
         w_ih_load    = w_hold_live && w_fresh_live;
      end else if (w_fresh_live) begin
         w_ih_vld_nxt = 1'b1;
         w_ih_load    = 1'b1;
         w_drop       = w_hold_live;
      end
      w_ih_idx_nxt  = w_ih_load ? idx_agingTb  : r_ih_idx;
      w_ih_data_nxt = w_ih_load ? data_agingTb : r_ih_data;
   end

   // Table write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_widx] <= w_wdata;
   end

   // Stage p0 -> p1: table lookup plus this cycle's commit, except the
   // inspector write issued together with the read (read sees the old value).
   always_comb begin
      w_rd_fwd_p0 = r_mem[idx_agingTb];
      if (w_we && w_widx == idx_agingTb && !(w_excl && w_wsrc_fresh))
         w_rd_fwd_p0 = w_wdata;
   end

   // Stage p1 -> p2: next cycle's commit, then any inspector write left in hold.
   always_comb begin
      w_rd_fwd_p1 = r_rd_data_p1;
      if (w_we && w_widx == r_rd_idx_p1 && !(r_rd_excl_p1 && w_wsrc_ins))
         w_rd_fwd_p1 = w_wdata;
      if (w_ih_vld_nxt && w_ih_idx_nxt == r_rd_idx_p1 && !r_rd_excl_p1)
         w_rd_fwd_p1 = w_ih_data_nxt;
   end

   // Control registers: hold valids, read pipeline valids, ctx and drop count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_uh_vld     <= 1'b0;
         r_ih_vld     <= 1'b0;
         r_rd_vld_p1  <= 1'b0;
         r_rd_excl_p1 <= 1'b0;
         r_rd_vld_p2  <= 1'b0;
         r_ctx        <= '0;
         r_drop_cnt   <= '0;
      end else begin
         r_uh_vld     <= w_uh_vld_nxt;
         r_ih_vld     <= w_ih_vld_nxt;
         r_rd_vld_p1  <= w_rd;
         r_rd_excl_p1 <= w_excl;
         r_rd_vld_p2  <= r_rd_vld_p1;
         // Stage p2 -> output: ctx holds until the next read response.
         if (r_rd_vld_p2) r_ctx <= r_rd_data_p2;
         if (w_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
      end
   end

   // Datapath registers: hold payloads and read pipeline data.
   always_ff @(posedge clk) begin
      if (w_uh_load) begin
         r_uh_idx  <= upd_idx;
         r_uh_data <= mk_entry(1'b0, cur_timestamp);
      end
      r_ih_idx     <= w_ih_idx_nxt;
      r_ih_data    <= w_ih_data_nxt;
      r_rd_idx_p1  <= idx_agingTb;
      r_rd_data_p1 <= w_rd_fwd_p0;
      r_rd_data_p2 <= w_rd_fwd_p1;
   end

   assign ctx_agingTb = r_ctx;
   assign tb_ready    = r_tb_ready;
   assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_aging_table_responder.sv
// Directed bench for aging_table_responder: init sweep, refresh/delete,
// inspector write arbitration, read latency and forwarding, drop counting.
module tb_aging_table_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  idx_agingTb;
   logic [8:0]  data_agingTb;
   logic        rdValid_agingTb;
   logic        wrValid_agingTb;
   logic [8:0]  ctx_agingTb;
   logic        upd_valid;
   logic [8:0]  upd_idx;
   logic        del_valid;
   logic [8:0]  del_idx;
   logic [7:0]  cur_timestamp;
   logic        tb_ready;
   logic [15:0] drop_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;

   aging_table_responder dut (
      .clk             (clk),
      .reset           (reset),
      .idx_agingTb     (idx_agingTb),
      .data_agingTb    (data_agingTb),
      .rdValid_agingTb (rdValid_agingTb),
      .wrValid_agingTb (wrValid_agingTb),
      .ctx_agingTb     (ctx_agingTb),
      .upd_valid       (upd_valid),
      .upd_idx         (upd_idx),
      .del_valid       (del_valid),
      .del_idx         (del_idx),
      .cur_timestamp   (cur_timestamp),
      .tb_ready        (tb_ready),
      .drop_cnt        (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Read request sampled at edge N, ctx checked just after edge N+2.
   task automatic rd_check(input logic [8:0] ix, input logic [8:0] exp, input string tag);
      idx_agingTb     = ix;
      rdValid_agingTb = 1'b1;
      step();
      rdValid_agingTb = 1'b0;
      step();
      step();
      check(tag, 16'(ctx_agingTb), 16'(exp));
   endtask

   task automatic upd_once(input logic [8:0] ix, input logic [7:0] ts);
      upd_valid     = 1'b1;
      upd_idx       = ix;
      cur_timestamp = ts;
      step();
      upd_valid     = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!tb_ready && n < 600) begin
         step();
         n++;
      end
   endtask

   initial begin
      reset = 1'b1;
      idx_agingTb = '0; data_agingTb = '0; rdValid_agingTb = 1'b0; wrValid_agingTb = 1'b0;
      upd_valid = 1'b0; upd_idx = '0; del_valid = 1'b0; del_idx = '0; cur_timestamp = '0;
      step(); step(); step();
      check("rst_ctx", 16'(ctx_agingTb), 16'h0);
      check("rst_ready", 16'(tb_ready), 16'h0);
      check("rst_drop", drop_cnt, 16'h0);

      // Init sweep: 512 edges until ready.
      reset = 1'b0;
      wait_ready(cyc);
      check("init_cycles", 16'(cyc), 16'd512);

      // Read of last entry, with latency check at N+1.
      idx_agingTb = 9'h1FF; rdValid_agingTb = 1'b1;
      step();
      rdValid_agingTb = 1'b0;
      step();
      check("rd_lat_n1", 16'(ctx_agingTb), 16'h0);
      step();
      check("rd_1ff", 16'(ctx_agingTb), 16'h100);

      // Refresh idx 5, read two cycles later.
      upd_once(9'd5, 8'h20);
      step();
      idx_agingTb = 9'd5; rdValid_agingTb = 1'b1;
      step();
      rdValid_agingTb = 1'b0;
      step();
      check("upd5_hold_n1", 16'(ctx_agingTb), 16'h100);
      step();
      check("upd5_rd", 16'(ctx_agingTb), 16'h020);

      // Inspector write collides with refresh on idx 7: discarded.
      wrValid_agingTb = 1'b1; idx_agingTb = 9'd7; data_agingTb = 9'h100;
      upd_valid = 1'b1; upd_idx = 9'd7; cur_timestamp = 8'h33;
      step();
      wrValid_agingTb = 1'b0; upd_valid = 1'b0;
      step();
      rd_check(9'd7, 9'h033, "collide7_rd");
      check("collide7_drop", drop_cnt, 16'h0);

      // Inspector write idx 3 loses to refresh idx 4, then commits from hold.
      upd_once(9'd3, 8'h44);
      wrValid_agingTb = 1'b1; idx_agingTb = 9'd3; data_agingTb = 9'h100;
      upd_valid = 1'b1; upd_idx = 9'd4; cur_timestamp = 8'h55;
      step();
      wrValid_agingTb = 1'b0; upd_valid = 1'b0;
      step();
      rd_check(9'd4, 9'h055, "hold_rd4");
      rd_check(9'd3, 9'h100, "hold_rd3");
      check("hold_drop", drop_cnt, 16'h0);

      // Refresh and read idx 9 on the same edge: forwarded.
      upd_valid = 1'b1; upd_idx = 9'd9; cur_timestamp = 8'h66;
      rd_check(9'd9, 9'h066, "fwd_upd9");
      upd_valid = 1'b0;

      // Read and inspector write on the same idx/edge: old value, then new.
      wrValid_agingTb = 1'b1; data_agingTb = 9'h0AB;
      idx_agingTb = 9'h10; rdValid_agingTb = 1'b1;
      step();
      wrValid_agingTb = 1'b0; rdValid_agingTb = 1'b0;
      step(); step();
      check("rdwr_old", 16'(ctx_agingTb), 16'h100);
      rd_check(9'h10, 9'h0AB, "rdwr_new");

      // Delete and refresh on different idx: refresh lands one cycle later.
      upd_once(9'h30, 8'h5A);
      del_valid = 1'b1; del_idx = 9'h30;
      upd_valid = 1'b1; upd_idx = 9'h31; cur_timestamp = 8'h12;
      step();
      del_valid = 1'b0; upd_valid = 1'b0;
      rd_check(9'h30, 9'h100, "del30");
      rd_check(9'h31, 9'h012, "delupd31");

      // Delete and refresh on the same idx: delete wins.
      upd_once(9'h40, 8'h50);
      del_valid = 1'b1; del_idx = 9'h40;
      upd_valid = 1'b1; upd_idx = 9'h40; cur_timestamp = 8'h51;
      step();
      del_valid = 1'b0; upd_valid = 1'b0;
      step();
      rd_check(9'h40, 9'h100, "delupd40");

      // Continuous refresh on idx 1 starves two inspector writes to idx 2.
      upd_valid = 1'b1; upd_idx = 9'd1; cur_timestamp = 8'h77;
      wrValid_agingTb = 1'b1; idx_agingTb = 9'd2; data_agingTb = 9'h0A1;
      step();
      data_agingTb = 9'h0A2;
      step();
      wrValid_agingTb = 1'b0;
      check("starve_drop", drop_cnt, 16'h1);
      rd_check(9'd2, 9'h0A2, "starve_fwd");
      upd_valid = 1'b0;
      step(); step();
      rd_check(9'd2, 9'h0A2, "starve_commit");
      rd_check(9'd1, 9'h077, "starve_upd1");

      // Mid-run reset: outputs clear at once, sweep restarts.
      reset = 1'b1;
      #1;
      check("mid_rst_ready", 16'(tb_ready), 16'h0);
      check("mid_rst_drop", drop_cnt, 16'h0);
      check("mid_rst_ctx", 16'(ctx_agingTb), 16'h0);
      step();
      reset = 1'b0;
      wait_ready(cyc);
      check("reinit_cycles", 16'(cyc), 16'd512);
      rd_check(9'd2, 9'h100, "reinit_rd2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aging_table_responder.md
Name: aging_table_responder

Overview:
- Owns the connection aging table: one entry per connection, storing an aging tag and the last-seen timestamp.
- Serves the time-out inspector's read/write port (idx/data/rdValid/wrValid in, ctx out) with fixed 2-cycle read latency.
- Also serves the connection-search path, which refreshes a connection's timestamp on every hit and retires deleted connections.
- Drives tb_ready, which gates the inspector's aging_enable until the table is initialised.

Parameters:
- w_agingTb, 9, entry width: bit w_agingTb-1 is the aging tag, bits w_timestamp-1:0 are the timestamp.
- d_agingTb, 9, index width; the table holds 2^d_agingTb entries.
- w_timestamp, 8, timestamp width.
- b_agingTag_agingTb, 9, one-based position of the aging tag; the tag is entry bit b_agingTag_agingTb-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- idx_agingTb  in  d_agingTb  inspector index, shared by read and write.
- data_agingTb  in  w_agingTb  inspector write data.
- rdValid_agingTb  in  1  inspector read request.
- wrValid_agingTb  in  1  inspector write request.
- ctx_agingTb  out  w_agingTb  inspector read data.
- upd_valid  in  1  connection-search refresh request.
- upd_idx  in  d_agingTb  index to refresh.
- del_valid  in  1  connection delete request.
- del_idx  in  d_agingTb  index to delete.
- cur_timestamp  in  w_timestamp  current time.
- tb_ready  out  1  table initialised; drives the inspector's aging_enable.
- drop_cnt  out  16  count of dropped inspector writes, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - ctx_agingTb=0, tb_ready=0, drop_cnt=0, hold register empty, state=INIT, init counter=0.
  - Table contents are not reset.
  - Reset asserted mid-operation returns to INIT and restarts the sweep from 0.
- State INIT:
  - Writes {1'b1, w_timestamp'h0} (tagged, i.e. never reported) to entry init_cnt, one entry per cycle.
  - After the write to entry 2^d_agingTb-1 (512 cycles at default), moves to RUN and sets tb_ready=1 on the same edge.
  - All requests are ignored in INIT.
- State RUN, request sources (all sampled at edge N):
  - Refresh: upd_valid writes {1'b0, cur_timestamp} to upd_idx.
  - Delete: del_valid writes {1'b1, 8'h00} to del_idx.
  - Inspector write: wrValid writes data_agingTb to idx_agingTb.
- Write arbitration (one table write per cycle), priority del > upd > hold > new inspector write:
  - Inspector writes that lose arbitration go to a 1-entry hold register and are retried each cycle.
  - A pending or held inspector write whose idx equals an upd_idx or del_idx written in the same cycle is discarded, not counted. A fresh refresh must never be re-tagged as aged.
  - An inspector write arriving while hold is occupied and hold cannot retire: the new write replaces hold and drop_cnt increments.
  - If del and upd are both valid on different idx, the upd is applied on the next cycle via a 1-entry upd hold. Same idx: del wins and the upd is discarded.
- Reads:
  - rdValid at edge N loads ctx_agingTb at edge N+2; ctx is held until the next read response.
  - Read-after-write coherence: ctx reflects every table write committed at or before edge N+1 for that idx, including same-cycle writes (forwarding path).
  - A held (not yet committed) inspector write to the same idx is also forwarded.
- rdValid and wrValid asserted in the same cycle on the same idx: the read returns the old value.
- Index arithmetic: init counter wraps modulo 2^d_agingTb, so there are no out-of-range indices. Timestamps are stored unmodified; no arithmetic on timestamps.
- drop_cnt saturates at 16'hFFFF.

Test Plan:
- Reset released -> tb_ready stays 0 for 512 cycles and rises on cycle 512; a read of idx 0x1FF afterwards returns 9'h100.
- upd_valid idx=5 with cur_timestamp=8'h20; rdValid idx=5 two cycles later -> ctx_agingTb=9'h020 exactly 2 cycles after the read request.
- Same edge: wrValid idx=7 data 9'h100 and upd_valid idx=7 ts=8'h33 -> inspector write discarded; a later read returns 9'h033; drop_cnt=0.
- Same edge: wrValid idx=3 and upd_valid idx=4 -> upd commits first, hold commits next cycle; reads return idx4=9'h0TS and idx3=9'h100.
- Back-to-back: upd_valid idx=9 at edge N, rdValid idx=9 at edge N -> ctx at N+2 shows the new value via forwarding.
- Continuous upd_valid on idx 1 while the inspector writes idx 2 twice -> second write replaces hold, drop_cnt=1; assert reset mid-run -> tb_ready=0 and drop_cnt=0 immediately, sweep restarts.
